// File: rtl/pcileech_tlps_pkg.sv
// Shared types for the 128-bit TLP stream helpers: legal DW-keep patterns, lane index, serializer states.
package pcileech_tlps_pkg;

    localparam logic [3:0] KEEP_NONE_DW = 4'b0000;
    localparam logic [3:0] KEEP_1DW     = 4'b0001;
    localparam logic [3:0] KEEP_2DW     = 4'b0011;
    localparam logic [3:0] KEEP_3DW     = 4'b0111;
    localparam logic [3:0] KEEP_4DW     = 4'b1111;

    typedef logic [1:0] lane_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    typedef enum logic [1:0] {
        KEEP_LEGAL = 2'd0,
        KEEP_NONE  = 2'd1,
        KEEP_BAD   = 2'd2
    } keep_class_t;

    function automatic keep_class_t keep_class(input logic [3:0] keep);
        case (keep)
            KEEP_1DW, KEEP_2DW, KEEP_3DW, KEEP_4DW: return KEEP_LEGAL;
            KEEP_NONE_DW:                           return KEEP_NONE;
            default:                                return KEEP_BAD;
        endcase
    endfunction

    // Highest kept lane of a legal (contiguous from lane 0) keep pattern.
    function automatic lane_t keep_hi_lane(input logic [3:0] keep);
        case (keep)
            KEEP_2DW: return 2'd1;
            KEEP_3DW: return 2'd2;
            KEEP_4DW: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pcileech_tlps128_dw_serializer.sv
// Splits 128-bit TLP beats into a 32-bit DW stream, lane 0 first; first DW one clk after accept, 1 DW/clk sustained.
// Backpressure: dw_ready stalls the current DW in place; tready only opens when empty or as the last kept lane leaves.
module pcileech_tlps128_dw_serializer
    import pcileech_tlps_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_pcie,
    input  logic             rst_n,
    input  logic [127:0]     tlps_in_tdata,
    input  logic [3:0]       tlps_in_tkeepdw,
    input  logic             tlps_in_tlast,
    input  logic [8:0]       tlps_in_tuser,
    input  logic             tlps_in_tvalid,
    output logic             tlps_in_tready,
    output logic [31:0]      dw_data,
    output logic             dw_valid,
    output logic             dw_first,
    output logic             dw_last,
    input  logic             dw_ready,
    output logic             err_keep,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ser_state_t   state, state_nxt;
    lane_t        lane, lane_nxt, hold_hi;
    logic [127:0] hold_data;
    logic         hold_first, hold_last;
    logic         dw_hs, last_hs, accept, load;
    keep_class_t  keep_cls;
    logic [31:0]  lane_dw;
    logic         unused_tuser;

    // Only the first-beat flag is meaningful here; the rest of tuser passes by untouched.
    assign unused_tuser = ^tlps_in_tuser[8:1];

    assign keep_cls       = keep_class(tlps_in_tkeepdw);
    assign dw_valid       = (state == ST_SHIFT);
    assign lane_dw        = hold_data[{lane, 5'd0} +: 32];
    assign dw_data        = dw_valid ? lane_dw : 32'd0;
    assign dw_first       = dw_valid && hold_first && (lane == 2'd0);
    assign dw_last        = dw_valid && hold_last && (lane == hold_hi);
    assign dw_hs          = dw_valid && dw_ready;
    assign last_hs        = dw_hs && (lane == hold_hi);
    assign tlps_in_tready = rst_n && ((state == ST_EMPTY) || last_hs);
    assign accept         = tlps_in_tvalid && tlps_in_tready;

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        load      = 1'b0;
        if (accept && (keep_cls == KEEP_LEGAL)) begin
            load      = 1'b1;
            state_nxt = ST_SHIFT;
            lane_nxt  = 2'd0;
        end else if (last_hs) begin
            // Empty or illegal beats accepted here are dropped, so the register drains.
            state_nxt = ST_EMPTY;
            lane_nxt  = 2'd0;
        end else if (dw_hs) begin
            lane_nxt  = lane + 2'd1;
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            lane       <= 2'd0;
            hold_data  <= '0;
            hold_first <= 1'b0;
            hold_last  <= 1'b0;
            hold_hi    <= 2'd0;
            err_keep   <= 1'b0;
            pkt_count  <= '0;
        end else begin
            state    <= state_nxt;
            lane     <= lane_nxt;
            err_keep <= accept && (keep_cls == KEEP_BAD);
            if (load) begin
                hold_data  <= tlps_in_tdata;
                hold_first <= tlps_in_tuser[0];
                hold_last  <= tlps_in_tlast;
                hold_hi    <= keep_hi_lane(tlps_in_tkeepdw);
            end
            if (dw_hs && dw_last) begin
                pkt_count <= pkt_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_dw_serializer.sv
// Directed bench for the DW serializer: beats driven from a queue, emitted DWs logged with cycle stamps.
module tb_pcileech_tlps128_dw_serializer;

    logic         clk_pcie = 1'b0;
    logic         rst_n;
    logic [127:0] tlps_in_tdata;
    logic [3:0]   tlps_in_tkeepdw;
    logic         tlps_in_tlast;
    logic [8:0]   tlps_in_tuser;
    logic         tlps_in_tvalid;
    logic         tlps_in_tready;
    logic [31:0]  dw_data;
    logic         dw_valid, dw_first, dw_last, dw_ready, err_keep;
    logic [15:0]  pkt_count;

    always #5 clk_pcie = ~clk_pcie;

    pcileech_tlps128_dw_serializer #(.CNT_W(16)) dut (
        .clk_pcie        (clk_pcie),
        .rst_n           (rst_n),
        .tlps_in_tdata   (tlps_in_tdata),
        .tlps_in_tkeepdw (tlps_in_tkeepdw),
        .tlps_in_tlast   (tlps_in_tlast),
        .tlps_in_tuser   (tlps_in_tuser),
        .tlps_in_tvalid  (tlps_in_tvalid),
        .tlps_in_tready  (tlps_in_tready),
        .dw_data         (dw_data),
        .dw_valid        (dw_valid),
        .dw_first        (dw_first),
        .dw_last         (dw_last),
        .dw_ready        (dw_ready),
        .err_keep        (err_keep),
        .pkt_count       (pkt_count)
    );

    typedef struct {
        logic [127:0] d;
        logic [3:0]   k;
        logic         f;
        logic         l;
    } beat_t;

    beat_t       bq[$];
    logic        rdy_pat[$];
    logic [31:0] got_d[$];
    logic        got_f[$];
    logic        got_l[$];
    int          got_c[$];
    logic        trdy_log[$];
    int          err_pulses;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic add_beat(input logic [127:0] d, input logic [3:0] k, input logic f, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.f = f; b.l = l;
        bq.push_back(b);
    endtask

    task automatic clear_logs();
        got_d.delete(); got_f.delete(); got_l.delete(); got_c.delete();
        trdy_log.delete(); rdy_pat.delete();
        err_pulses = 0;
    endtask

    // Drives queued beats and the dw_ready pattern; stops after stop_cyc cycles, or (stop_cyc==0) once idle.
    task automatic run(input int max_cyc, input int stop_cyc);
        int          idle = 0;
        bit          done = 1'b0;
        logic        stall = 1'b0;
        logic [33:0] held = '0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk_pcie); #1;
            if (bq.size() > 0) begin
                tlps_in_tvalid  = 1'b1;
                tlps_in_tdata   = bq[0].d;
                tlps_in_tkeepdw = bq[0].k;
                tlps_in_tuser   = {8'hA5, bq[0].f};
                tlps_in_tlast   = bq[0].l;
            end else begin
                tlps_in_tvalid  = 1'b0;
            end
            dw_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
            @(negedge clk_pcie);
            if (stall) check("hold_on_stall", {dw_valid, dw_first, dw_last, dw_data}, {1'b1, held});
            stall = dw_valid && !dw_ready;
            held  = {dw_first, dw_last, dw_data};
            trdy_log.push_back(tlps_in_tready);
            if (err_keep) err_pulses++;
            if (dw_valid && dw_ready) begin
                got_d.push_back(dw_data);
                got_f.push_back(dw_first);
                got_l.push_back(dw_last);
                got_c.push_back(c);
            end
            if (tlps_in_tvalid && tlps_in_tready) void'(bq.pop_front());
            idle = (bq.size() == 0 && !dw_valid) ? idle + 1 : 0;
            if ((stop_cyc > 0 && c + 1 >= stop_cyc) || (stop_cyc == 0 && idle >= 3)) done = 1'b1;
        end
        if (!done) check("run_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]   fl;
        logic [4:0]   ll;
        logic [7:0]   tv;
        logic [127:0] d;
        int           bad;

        // Reset state, with a beat offered so tready must be forced low.
        rst_n           = 1'b0;
        tlps_in_tvalid  = 1'b1;
        tlps_in_tdata   = {4{32'hFFFF_FFFF}};
        tlps_in_tkeepdw = 4'b1111;
        tlps_in_tlast   = 1'b1;
        tlps_in_tuser   = 9'h001;
        dw_ready        = 1'b1;
        clear_logs();
        #22;
        check("rst_outputs", {dw_valid, dw_first, dw_last, err_keep, tlps_in_tready, dw_data, pkt_count},
              {5'b0, 32'd0, 16'd0});
        @(posedge clk_pcie); #1;
        rst_n = 1'b1; tlps_in_tvalid = 1'b0;
        #1;
        check("rst_release_tready", tlps_in_tready, 1'b1);

        // 3DW header beat plus one payload DW.
        clear_logs();
        add_beat(128'h00000003_0000AAAA_0100000F_4A000001, 4'b1111, 1'b1, 1'b0);
        add_beat({96'd0, 32'h12345678}, 4'b0001, 1'b0, 1'b1);
        run(50, 0);
        check("tlp5_count", got_d.size(), 5);
        if (got_d.size() == 5) begin
            check("tlp5_dw0", got_d[0], 32'h4A000001);
            check("tlp5_dw1", got_d[1], 32'h0100000F);
            check("tlp5_dw2", got_d[2], 32'h0000AAAA);
            check("tlp5_dw3", got_d[3], 32'h00000003);
            check("tlp5_dw4", got_d[4], 32'h12345678);
            fl = {got_f[0], got_f[1], got_f[2], got_f[3], got_f[4]};
            ll = {got_l[0], got_l[1], got_l[2], got_l[3], got_l[4]};
            check("tlp5_first", fl, 5'b10000);
            check("tlp5_last", ll, 5'b00001);
            check("tlp5_latency", got_c[0], 1);
            check("tlp5_consecutive", got_c[4] - got_c[0], 4);
        end
        check("tlp5_pkt_count", pkt_count, 16'd1);

        // Stalling consumer: ready 1,0,0,1 repeated after the accept cycle.
        clear_logs();
        add_beat({32'h29000003, 32'h29000002, 32'h29000001, 32'h29000000}, 4'b1111, 1'b1, 1'b1);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run(50, 0);
        check("stall_count", got_d.size(), 4);
        if (got_d.size() == 4) begin
            check("stall_dw0", got_d[0], 32'h29000000);
            check("stall_dw3", got_d[3], 32'h29000003);
            check("stall_cycles", {got_c[0][7:0], got_c[1][7:0], got_c[2][7:0], got_c[3][7:0]},
                  {8'd1, 8'd4, 8'd5, 8'd8});
        end
        if (trdy_log.size() >= 10) begin
            tv = '0;
            for (int i = 1; i <= 8; i++) tv = {tv[6:0], trdy_log[i]};
            check("stall_tready_trace", tv, 8'b0000_0001);
            check("stall_tready_idle", trdy_log[9], 1'b1);
        end
        check("stall_pkt_count", pkt_count, 16'd2);

        // Illegal keep: dropped, one err pulse; empty keep: dropped silently.
        clear_logs();
        add_beat({4{32'hBAD0BAD0}}, 4'b0101, 1'b1, 1'b1);
        run(50, 0);
        check("bad_keep_no_dw", got_d.size(), 0);
        check("bad_keep_err_pulses", err_pulses, 1);
        clear_logs();
        add_beat({4{32'h00000000}}, 4'b0000, 1'b1, 1'b1);
        run(50, 0);
        check("zero_keep_no_dw", got_d.size(), 0);
        check("zero_keep_no_err", err_pulses, 0);
        clear_logs();
        add_beat({4{32'hBAD1BAD1}}, 4'b1010, 1'b1, 1'b1);
        add_beat({4{32'hBAD2BAD2}}, 4'b1000, 1'b1, 1'b1);
        run(50, 0);
        check("bad_keep_pair_err", err_pulses, 2);
        check("bad_keep_pkt_count", pkt_count, 16'd2);

        // Reset after two of four DWs have left.
        clear_logs();
        add_beat({32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 4'b1111, 1'b1, 1'b1);
        run(20, 3);
        check("midrst_pre_count", got_d.size(), 2);
        @(posedge clk_pcie); #1;
        tlps_in_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {dw_valid, dw_first, dw_last, err_keep, tlps_in_tready, dw_data, pkt_count},
              {5'b0, 32'd0, 16'd0});
        repeat (2) @(posedge clk_pcie);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_release", {tlps_in_tready, dw_valid}, 2'b10);
        clear_logs();
        run(20, 0);
        check("midrst_no_leftover", got_d.size(), 0);

        // Counter wrap: 65535 single-DW TLPs, then one more.
        clear_logs();
        for (int i = 0; i < 65535; i++) add_beat({96'd0, 32'(i)}, 4'b0001, 1'b1, 1'b1);
        run(70000, 0);
        check("wrap_dw_total", got_d.size(), 65535);
        check("wrap_preset", pkt_count, 16'hFFFF);
        clear_logs();
        add_beat({96'd0, 32'h0000FFFF}, 4'b0001, 1'b1, 1'b1);
        run(50, 0);
        check("wrap_to_zero", pkt_count, 16'd0);

        // 100 back-to-back 4-DW beats.
        clear_logs();
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 4; j++) d[j*32 +: 32] = 32'h33000000 + 32'(i * 4 + j);
            add_beat(d, 4'b1111, 1'b1, 1'b1);
        end
        run(1000, 0);
        check("b2b_dw_total", got_d.size(), 400);
        if (got_d.size() == 400) begin
            check("b2b_span", got_c[399] - got_c[0], 399);
            bad = 0;
            for (int n = 0; n < 400; n++) if (got_d[n] !== 32'h33000000 + 32'(n)) bad++;
            check("b2b_data_errors", bad, 0);
        end
        check("b2b_pkt_count", pkt_count, 16'd100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pcileech_tlps128_dw_serializer.md
PCILEECH_TLPS128_DW_SERIALIZER -- requirements
Module: pcileech_tlps128_dw_serializer

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of packet counter output.
REQ-002 SHALL have port: clk_pcie  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: tlps_in  IfAXIS128.sink  -  128-bit TLP stream in: tdata[127:0], tkeepdw[3:0], tlast, tuser[8:0] (tuser[0]=first beat), tvalid, tready (out).
REQ-005 SHALL have port: dw_data  output  32  serialized DW, lane 0 = tdata[31:0] first.
REQ-006 SHALL have port: dw_valid  output  1  dw_data/dw_first/dw_last valid.
REQ-007 SHALL have port: dw_first  output  1  first DW of a TLP.
REQ-008 SHALL have port: dw_last  output  1  last DW of a TLP.
REQ-009 SHALL have port: dw_ready  input  1  downstream accepts DW when high with dw_valid.
REQ-010 SHALL have port: err_keep  output  1  one-cycle pulse, illegal tkeepdw beat dropped.
REQ-011 SHALL have port: pkt_count  output  CNT_W  TLPs fully emitted, wraps modulo 2^CNT_W.

Function
REQ-012 SHALL hold one 128-bit beat in a holding register with first, tlast, keep, and a 2-bit lane index; states EMPTY and SHIFT.
REQ-013 SHALL accept a beat on tvalid && tready; tready = rst_n && (EMPTY || (dw_valid && dw_ready && current lane is highest kept lane)).
REQ-014 SHALL present the first DW of an accepted beat on the cycle after acceptance (latency 1 clk); sustained throughput 1 DW/clk with back-to-back beats and no bubble.
REQ-015 SHALL treat legal tkeepdw as 0001, 0011, 0111, 1111; the highest kept lane = popcount-1.
REQ-016 SHALL accept and silently drop beats with tkeepdw 0000, with no DW emitted and no err_keep.
REQ-017 SHALL accept and drop beats with any other tkeepdw, pulsing err_keep one cycle after acceptance.
REQ-018 SHALL drive dw_first = beat first && lane==0; dw_last = beat tlast && lane==highest kept lane.
REQ-019 SHALL advance lane only on dw_valid && dw_ready; dw_data/dw_first/dw_last SHALL hold stable while dw_valid && !dw_ready.
REQ-020 SHALL transition SHIFT->EMPTY when the last kept lane handshakes and no new beat is accepted the same cycle; SHIFT->SHIFT with lane=0 on simultaneous accept.
REQ-021 SHALL increment pkt_count on dw_valid && dw_ready && dw_last; it wraps from all-ones to 0.
REQ-022 SHALL pass tuser[8:1] unused; no reordering or TLP content inspection.

Reset
REQ-023 SHALL, while rst_n low, force dw_valid=0, dw_first=0, dw_last=0, dw_data=0, err_keep=0, tready=0, pkt_count=0, state EMPTY, lane=0.
REQ-024 SHALL discard a partially emitted beat on reset mid-operation; no DW of it appears after rst_n rises.
REQ-025 SHALL raise tready in the first cycle after rst_n deasserts.

Structure
REQ-026 SHALL place legal tkeepdw constants, lane index typedef and state enum in shared package pcileech_tlps_pkg.
REQ-027 SHALL be implemented without a sub-module; lane mux and counter are inline.

Verification
REQ-028 SHALL verify 3DW-header TLP beat tdata=0x00000003_0000AAAA_0100000F_4A000001, keep=1111, first=1, tlast=0, then keep=0001 tlast=1 data 0x12345678 with dw_ready=1 -> 5 DWs 0x4A000001,0x0100000F,0x0000AAAA,0x00000003,0x12345678 on consecutive cycles, dw_first on DW0, dw_last on DW4, pkt_count=1.
REQ-029 SHALL verify dw_ready toggling 1,0,0,1 per cycle -> dw_data held unchanged during stalls, tready low until final lane handshakes.
REQ-030 SHALL verify tkeepdw=0101 beat -> accepted, no dw_valid, err_keep high exactly one cycle; tkeepdw=0000 -> no dw_valid, no err_keep.
REQ-031 SHALL verify rst_n pulled low after 2 of 4 DWs emitted -> outputs zero immediately, remaining 2 DWs never appear, tready=1 first cycle after release.
REQ-032 SHALL verify pkt_count preset by 65535 single-DW TLPs (keep=0001, first=1, tlast=1) plus one more -> pkt_count wraps to 0.
REQ-033 SHALL verify 100 back-to-back 4-DW beats with dw_ready=1 -> 400 DWs in 400 consecutive cycles, no bubbles.
